reg_file_mp: RTL
================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter REG_COUNT, default 11, number of registers (index 0..REG_COUNT-1; index 0 = R).
REQ-002 SHALL have parameter REG_WIDTH, default 12, bits per register.
REQ-003 SHALL have parameter DEFAULT_SEL, default 8, register driven on a read port whose select is not exactly one-hot.
REQ-004 SHALL have parameter RESET_VALUE, default 0, REG_WIDTH-bit value loaded into every register on reset.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 write_en  in  REG_COUNT  write select, expected one-hot.
REQ-008 datain  in  REG_WIDTH  write data from bus.
REQ-009 inc_en  in  REG_COUNT  increment select, multi-hot allowed.
REQ-010 read_en_a  in  REG_COUNT  port A read select, one-hot.
REQ-011 read_en_b  in  REG_COUNT  port B read select, one-hot.
REQ-012 err_clr  in  1  clears write_err.
REQ-013 dataout_a  out  REG_WIDTH  port A read data.
REQ-014 dataout_b  out  REG_WIDTH  port B read data.
REQ-015 wr_ack  out  1  one-cycle pulse, a write was committed the previous edge.
REQ-016 inc_wrap  out  1  one-cycle pulse, some increment wrapped the previous edge.
REQ-017 write_err  out  1  sticky flag, write_en had more than one bit set.

Function
REQ-018 Write: at rising edge with write_en != 0, lowest set index k SHALL load datain; all other write_en bits ignored.
REQ-019 Increment: each register i with inc_en[i]=1 and not the written index k SHALL load reg[i]+1 modulo 2^REG_WIDTH.
REQ-020 Same-index write and increment in one cycle: write SHALL win; no increment, no wrap for that index.
REQ-021 Registers with neither write nor increment SHALL hold value.
REQ-022 Reads SHALL be combinational from current register contents (no write-through bypass); a write is visible on dataout the cycle after its edge.
REQ-023 Read select exactly one-hot at index j: dataout SHALL equal reg[j]; zero or multi-hot select: dataout SHALL equal reg[DEFAULT_SEL].
REQ-024 Ports A and B SHALL be independent; both may select the same register.
REQ-025 wr_ack SHALL be registered: 1 for exactly the cycle after any edge with write_en != 0, else 0.
REQ-026 inc_wrap SHALL be registered: 1 for the cycle after an edge where any effective increment took a register from all-ones to 0.
REQ-027 write_err SHALL set at an edge where write_en has two or more bits set, and stay set until an edge with err_clr=1 and no new multi-hot write.
REQ-028 Multi-hot write coincident with err_clr: set SHALL win.
REQ-029 Writes and increments SHALL proceed normally while write_err is set.

Reset
REQ-030 reset low SHALL immediately, independent of clk, set every register to RESET_VALUE and wr_ack, inc_wrap, write_err to 0.
REQ-031 While reset is low, all inputs SHALL be ignored; dataout_a/b reflect RESET_VALUE per REQ-023.
REQ-032 First edge after reset deassertion SHALL be a normal operating edge; reset asserted mid-cycle discards any pending update.

Verification
REQ-033 Reset, then read_en_a=1<<3 -> dataout_a=0x000; wr_ack, inc_wrap, write_err all 0.
REQ-034 write_en=1<<4, datain=0xABC; next cycle read_en_a=1<<4, read_en_b=1<<4 -> both 0xABC, wr_ack=1 for one cycle.
REQ-035 Write 0xFFF to reg 2, then inc_en=(1<<2)|(1<<5) -> reg2=0x000, reg5=0x001, inc_wrap=1 for one cycle.
REQ-036 write_en=(1<<1)|(1<<6), datain=0x123 -> only reg1=0x123, reg6 unchanged, write_err=1 and holds; err_clr pulse -> write_err=0.
REQ-037 write_en=1<<7, inc_en=1<<7, datain=0x055 -> reg7=0x055; read_en_a=0 -> dataout_a=reg[8].
REQ-038 Assert reset low between edges after loading reg0=0x777 -> dataout on reg0 becomes 0x000 before next edge.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port (lowest set write_en bit wins), a
// multi-hot increment port, and two independent one-hot combinational read ports.
module reg_file_mp #(
    parameter int                   REG_COUNT   = 11,
    parameter int                   REG_WIDTH   = 12,
    parameter int                   DEFAULT_SEL = 8,
    parameter logic [REG_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_COUNT-1:0] write_en,
    input  logic [REG_WIDTH-1:0] datain,
    input  logic [REG_COUNT-1:0] inc_en,
    input  logic [REG_COUNT-1:0] read_en_a,
    input  logic [REG_COUNT-1:0] read_en_b,
    input  logic                 err_clr,
    output logic [REG_WIDTH-1:0] dataout_a,
    output logic [REG_WIDTH-1:0] dataout_b,
    output logic                 wr_ack,
    output logic                 inc_wrap,
    output logic                 write_err
);

    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic [REG_WIDTH-1:0] regs [REG_COUNT];

    logic [REG_COUNT-1:0] wr_mask;
    logic [REG_COUNT-1:0] eff_inc;
    logic                 wr_any;
    logic                 wr_multi;
    logic                 wrap_any;
    logic [IDX_W-1:0]     idx_a;
    logic [IDX_W-1:0]     idx_b;

    // Non-one-hot selects (zero or multi-hot) fall back to DEFAULT_SEL.
    function automatic logic [IDX_W-1:0] sel_index(input logic [REG_COUNT-1:0] sel);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(DEFAULT_SEL);
        if ((sel != '0) && ((sel & (sel - REG_COUNT'(1))) == '0)) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (sel[i]) idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        wr_any   = |write_en;
        wr_multi = (write_en & (write_en - REG_COUNT'(1))) != '0;
        // Two's-complement trick isolates the lowest set bit: that index wins the write.
        wr_mask  = write_en & (~write_en + REG_COUNT'(1));
        eff_inc  = inc_en & ~wr_mask;
        wrap_any = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (eff_inc[i] && (regs[i] == '1)) wrap_any = 1'b1;
        end
    end

    always_comb begin
        idx_a     = sel_index(read_en_a);
        idx_b     = sel_index(read_en_b);
        dataout_a = regs[idx_a];
        dataout_b = regs[idx_b];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= RESET_VALUE;
            wr_ack    <= 1'b0;
            inc_wrap  <= 1'b0;
            write_err <= 1'b0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (wr_mask[i])      regs[i] <= datain;
                else if (eff_inc[i]) regs[i] <= regs[i] + REG_WIDTH'(1);
            end
            wr_ack   <= wr_any;
            inc_wrap <= wrap_any;
            // A new multi-hot write takes priority over a coincident clear.
            if (wr_multi)     write_err <= 1'b1;
            else if (err_clr) write_err <= 1'b0;
        end
    end

endmodule
